// File: rtl/tdc_pkg.sv
// Shared types and default sizes for the TDC measurement sequencer.
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_ACCUM,
        S_FINISH
    } tdc_state_t;

    localparam int TDC_CODE_W    = 6;
    localparam int TDC_MAX_LOG2N = 7;
    localparam int TDC_ACC_W     = TDC_CODE_W + TDC_MAX_LOG2N;
    localparam int TDC_TMR_W     = 8;

endpackage

// File: rtl/tdc_timeout_cnt.sv
// Loadable down-counter; expired flags the last cycle of the loaded interval.
module tdc_timeout_cnt
    import tdc_pkg::*;
#(
    parameter int W = TDC_TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // A count of one is the final cycle of the interval that was loaded.
    assign expired = (cnt == W'(1));

endmodule

// File: rtl/tdc_meas_seq.sv
// TDC measurement sequencer: clear/launch/capture 2^log2_n times, then report sum and average.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | waiting for start; results held
// S_CLEAR  | tdc_clr high, settle counter running
// S_LAUNCH | one-cycle launch pulse, timeout counter loaded
// S_WAIT   | waiting for tdc_valid or timeout expiry
// S_ACCUM  | add captured code, decide next round or finish
// S_FINISH | publish sum/result, pulse done on exit
module tdc_meas_seq
    import tdc_pkg::*;
#(
    parameter int CODE_W      = TDC_CODE_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 15,
    parameter int MAX_LOG2N   = TDC_MAX_LOG2N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        start,
    input  logic [2:0]                  log2_n,
    output logic                        tdc_clr,
    output logic                        tdc_launch,
    input  logic                        tdc_valid,
    input  logic [CODE_W-1:0]           tdc_code,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [CODE_W-1:0]           result,
    output logic [CODE_W+MAX_LOG2N-1:0] sum
);

    localparam int ACC_W = CODE_W + MAX_LOG2N;
    localparam int CNT_W = MAX_LOG2N + 1;
    localparam logic [2:0]           MAX_N     = 3'(MAX_LOG2N);
    localparam logic [TDC_TMR_W-1:0] SETTLE_V  = TDC_TMR_W'(SETTLE_CYC);
    localparam logic [TDC_TMR_W-1:0] TIMEOUT_V = TDC_TMR_W'(TIMEOUT_CYC);

    tdc_state_t           state;
    logic [2:0]           n_q;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     smp_cnt;
    logic [CNT_W-1:0]     smp_next;
    logic [CNT_W-1:0]     smp_target;
    logic                 last_smp;
    logic [CODE_W-1:0]    code_q;
    logic                 tmr_load;
    logic                 tmr_dec;
    logic [TDC_TMR_W-1:0] tmr_val;
    logic                 tmr_exp;

    assign smp_next   = smp_cnt + CNT_W'(1);
    assign smp_target = CNT_W'(1) << n_q;
    assign last_smp   = (smp_next == smp_target);

    // One counter serves both the settle interval and the capture timeout.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = SETTLE_V;
        case (state)
            S_IDLE:          tmr_load = start & ena;
            S_CLEAR, S_WAIT: tmr_dec  = 1'b1;
            S_LAUNCH: begin
                tmr_load = 1'b1;
                tmr_val  = TIMEOUT_V;
            end
            S_ACCUM:         tmr_load = ~last_smp;
            default:         tmr_load = 1'b0;
        endcase
    end

    tdc_timeout_cnt #(.W(TDC_TMR_W)) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_q        <= '0;
            acc        <= '0;
            smp_cnt    <= '0;
            code_q     <= '0;
            tdc_clr    <= 1'b0;
            tdc_launch <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            sum        <= '0;
        end else begin
            done <= 1'b0;
            if ((state != S_IDLE) && !ena) begin
                state      <= S_IDLE;
                tdc_clr    <= 1'b0;
                tdc_launch <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start && ena) begin
                        n_q     <= (int'(log2_n) > MAX_LOG2N) ? MAX_N : log2_n;
                        acc     <= '0;
                        smp_cnt <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        tdc_clr <= 1'b1;
                        state   <= S_CLEAR;
                    end
                    S_CLEAR: if (tmr_exp) begin
                        tdc_clr    <= 1'b0;
                        tdc_launch <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                    S_LAUNCH: begin
                        tdc_launch <= 1'b0;
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A capture on the expiry cycle still counts as a sample.
                        if (tdc_valid) begin
                            code_q <= tdc_code;
                            state  <= S_ACCUM;
                        end else if (tmr_exp) begin
                            err   <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                    S_ACCUM: begin
                        acc     <= acc + ACC_W'(code_q);
                        smp_cnt <= smp_next;
                        if (last_smp) begin
                            state <= S_FINISH;
                        end else begin
                            tdc_clr <= 1'b1;
                            state   <= S_CLEAR;
                        end
                    end
                    S_FINISH: begin
                        sum    <= acc;
                        result <= CODE_W'(acc >> n_q);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
